// File: rtl/seq_pkg.sv
// Shared types and constants for the frame sequencer: FSM state encoding,
// default IMU word width, overrun counter width and a saturating increment.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAPTURE   = 3'd1,
        PHYS_GO   = 3'd2,
        PHYS_WAIT = 3'd3,
        LED_GO    = 3'd4,
        LED_WAIT  = 3'd5
    } seq_state_t;

    localparam int IMU_W_DEFAULT = 96;
    localparam int OVR_W         = 8;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == {OVR_W{1'b1}}) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Brings a slow-domain toggle into clk through two flops and emits a
// one-cycle pulse for every level change (either edge) of the toggle.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle,
    output logic pulse
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= toggle;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign pulse = s2_r ^ s3_r;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: IMU snapshot -> physics step -> WS2812 refresh.
// Define SEQ_TIMEOUT_EN to build the PHYS_WAIT/LED_WAIT stall timeout.
module frame_sequencer
    import seq_pkg::*;
#(
    parameter int FRAME_CYCLES   = 833333,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int IMU_W          = IMU_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imu_toggle,
    input  logic [IMU_W-1:0] imu_data,
    output logic [IMU_W-1:0] snap_data,
    output logic             phys_start,
    input  logic             phys_done,
    output logic             led_start,
    input  logic             led_busy,
    input  logic             led_done,
    output logic             frame_busy,
    output logic             stale,
    output logic [OVR_W-1:0] overrun_cnt,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);

    if (FRAME_CYCLES < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("frame_sequencer: FRAME_CYCLES must be >= 8 and TIMEOUT_CYCLES >= 1");
    end

    seq_state_t       state_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             tick_r;
    logic [IMU_W-1:0] hold_r;
    logic             new_sample_r;
    logic             imu_edge_s;

`ifdef SEQ_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [ST_W-1:0] stall_r;
    logic            timeout_err_r;
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    toggle_sync u_imu_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .toggle (imu_toggle),
        .pulse  (imu_edge_s)
    );

    // Free-running frame period counter; tick is registered at wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= '0;
            tick_r      <= 1'b0;
        end else begin
            tick_r <= (frame_cnt_r == CNT_W'(FRAME_CYCLES - 1));
            if (frame_cnt_r == CNT_W'(FRAME_CYCLES - 1)) begin
                frame_cnt_r <= '0;
            end else begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end
    end

    // Latch each new IMU sample; a fresh edge outranks the CAPTURE clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r       <= '0;
            new_sample_r <= 1'b0;
        end else if (imu_edge_s) begin
            hold_r       <= imu_data;
            new_sample_r <= 1'b1;
        end else if (state_r == CAPTURE) begin
            new_sample_r <= 1'b0;
        end
    end

    // Frame FSM with registered strobes, status flags and overrun count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            snap_data   <= '0;
            phys_start  <= 1'b0;
            led_start   <= 1'b0;
            frame_busy  <= 1'b0;
            stale       <= 1'b0;
            overrun_cnt <= '0;
`ifdef SEQ_TIMEOUT_EN
            stall_r       <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            phys_start <= 1'b0;
            led_start  <= 1'b0;
            // Ticks are never queued: any tick seen outside IDLE is lost
            if (tick_r && (state_r != IDLE)) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end
            case (state_r)
                IDLE: begin
                    if (tick_r) begin
                        state_r    <= CAPTURE;
                        frame_busy <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (new_sample_r) begin
                        snap_data <= hold_r;
                        stale     <= 1'b0;
                    end else begin
                        stale     <= 1'b1;
                    end
                    state_r    <= PHYS_GO;
                    phys_start <= 1'b1;
                end
                PHYS_GO: begin
                    state_r <= PHYS_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    stall_r <= '0;
`endif
                end
                PHYS_WAIT: begin
                    if (phys_done) begin
                        state_r   <= LED_GO;
                        led_start <= !led_busy;
`ifdef SEQ_TIMEOUT_EN
                    end else if (stall_r == ST_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r       <= IDLE;
                        frame_busy    <= 1'b0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        stall_r <= stall_r + ST_W'(1);
`endif
                    end
                end
                LED_GO: begin
                    // led_start is high while still in LED_GO; leave once it has fired
                    if (led_start) begin
                        state_r <= LED_WAIT;
`ifdef SEQ_TIMEOUT_EN
                        stall_r <= '0;
`endif
                    end else begin
                        led_start <= !led_busy;
                    end
                end
                LED_WAIT: begin
                    if (led_done) begin
                        state_r    <= IDLE;
                        frame_busy <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    end else if (stall_r == ST_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r       <= IDLE;
                        frame_busy    <= 1'b0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        stall_r <= stall_r + ST_W'(1);
`endif
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    frame_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with FRAME_CYCLES=16, TIMEOUT_CYCLES=20.
// Cycle k is the sample point at the negedge after the k-th posedge following reset release.
module tb_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imu_toggle;
    logic [95:0] imu_data;
    logic [95:0] snap_data;
    logic        phys_start;
    logic        phys_done;
    logic        led_start;
    logic        led_busy;
    logic        led_done;
    logic        frame_busy;
    logic        stale;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    frame_sequencer #(
        .FRAME_CYCLES   (16),
        .TIMEOUT_CYCLES (20),
        .IMU_W          (96)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imu_toggle  (imu_toggle),
        .imu_data    (imu_data),
        .snap_data   (snap_data),
        .phys_start  (phys_start),
        .phys_done   (phys_done),
        .led_start   (led_start),
        .led_busy    (led_busy),
        .led_done    (led_done),
        .frame_busy  (frame_busy),
        .stale       (stale),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check96(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called in a PHYS_WAIT cycle with led_busy low; ends in IDLE
    task automatic frame_tail();
        phys_done = 1'b1;
        step_to(cyc + 1);
        phys_done = 1'b0;
        check1("led_start_pulse", led_start, 1'b1);
        step_to(cyc + 1);
        check1("led_start_single", led_start, 1'b0);
        led_done = 1'b1;
        step_to(cyc + 1);
        led_done = 1'b0;
        check1("idle_after_led_done", frame_busy, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        imu_toggle = 1'b0;
        imu_data   = 96'h0;
        phys_done  = 1'b0;
        led_busy   = 1'b0;
        led_done   = 1'b0;
        repeat (2) @(negedge clk);
        check96("rst_snap", snap_data, 96'h0);
        check1("rst_phys_start", phys_start, 1'b0);
        check1("rst_led_start", led_start, 1'b0);
        check1("rst_busy", frame_busy, 1'b0);
        check1("rst_stale", stale, 1'b0);
        check8("rst_overrun", overrun_cnt, 8'd0);
        check1("rst_timeout", timeout_err, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;

        // Frame 1: no sample ever arrived
        step_to(15);
        check1("f1_busy_c15", frame_busy, 1'b0);
        step_to(16);
        check1("f1_busy_c16", frame_busy, 1'b0);
        step_to(17);
        check1("f1_capture_busy", frame_busy, 1'b1);
        check1("f1_no_early_start", phys_start, 1'b0);
        step_to(18);
        check1("f1_phys_start", phys_start, 1'b1);
        check1("f1_stale", stale, 1'b1);
        check96("f1_snap", snap_data, 96'h0);
        step_to(19);
        check1("f1_phys_start_single", phys_start, 1'b0);
        frame_tail();

        // Frame 2: fresh sample A5A5
        imu_data   = 96'hA5A5;
        imu_toggle = ~imu_toggle;
        step_to(34);
        check1("f2_phys_start", phys_start, 1'b1);
        check96("f2_snap", snap_data, 96'hA5A5);
        check1("f2_stale", stale, 1'b0);
        step_to(35);
        frame_tail();

        // Frame 3: no new sample, snapshot held
        step_to(50);
        check1("f3_phys_start", phys_start, 1'b1);
        check96("f3_snap", snap_data, 96'hA5A5);
        check1("f3_stale", stale, 1'b1);
        step_to(51);
        frame_tail();

        // Frame 4: WS2812 still busy when LED_GO is reached
        led_busy = 1'b1;
        step_to(66);
        check1("f4_phys_start", phys_start, 1'b1);
        step_to(67);
        phys_done = 1'b1;
        step_to(68);
        phys_done = 1'b0;
        check1("f4_led_held_c68", led_start, 1'b0);
        check1("f4_busy_c68", frame_busy, 1'b1);
        step_to(69);
        check1("f4_led_held_c69", led_start, 1'b0);
        led_busy = 1'b0;
        step_to(70);
        check1("f4_led_start", led_start, 1'b1);
        step_to(71);
        check1("f4_led_single", led_start, 1'b0);
        led_done = 1'b1;
        step_to(72);
        led_done = 1'b0;
        check1("f4_idle", frame_busy, 1'b0);
        check8("f4_no_overrun", overrun_cnt, 8'd0);

        // Frame 5: sample 5555 pending, then 1234 arrives exactly in CAPTURE
        imu_data   = 96'h5555;
        imu_toggle = ~imu_toggle;
        step_to(79);
        imu_data   = 96'h1234;
        imu_toggle = ~imu_toggle;
        step_to(82);
        check1("f5_phys_start", phys_start, 1'b1);
        check96("f5_snap_old_hold", snap_data, 96'h5555);
        check1("f5_stale", stale, 1'b0);
        step_to(83);
        frame_tail();

        // Frame 6: the sample that collided with CAPTURE is not lost
        step_to(98);
        check1("f6_phys_start", phys_start, 1'b1);
        check96("f6_snap", snap_data, 96'h1234);
        check1("f6_stale", stale, 1'b0);
        step_to(99);
        frame_tail();

        // Frame 7: physics never finishes
        step_to(114);
        check1("f7_phys_start", phys_start, 1'b1);
        step_to(115);
`ifdef SEQ_TIMEOUT_EN
        step_to(134);
        check1("to_still_waiting", frame_busy, 1'b1);
        check1("to_not_yet", timeout_err, 1'b0);
        step_to(135);
        check1("to_back_idle", frame_busy, 1'b0);
        check1("to_err_set", timeout_err, 1'b1);
        check8("to_overrun", overrun_cnt, 8'd1);
        step_to(146);
        check1("to_next_phys_start", phys_start, 1'b1);
        step_to(147);
        frame_tail();
        check1("to_err_sticky", timeout_err, 1'b1);
        step_to(163);
        check1("to_in_phys_wait", frame_busy, 1'b1);
`else
        step_to(155);
        check8("stall_overrun_2", overrun_cnt, 8'd2);
        step_to(4300);
        check8("stall_overrun_sat", overrun_cnt, 8'd255);
        step_to(4400);
        check8("stall_overrun_nowrap", overrun_cnt, 8'd255);
        check1("stall_busy", frame_busy, 1'b1);
        check1("stall_no_timeout", timeout_err, 1'b0);
`endif

        // Asynchronous reset in the middle of PHYS_WAIT
        rst_n      = 1'b0;
        imu_toggle = 1'b0;
        #1;
        check1("mid_rst_busy", frame_busy, 1'b0);
        check96("mid_rst_snap", snap_data, 96'h0);
        check1("mid_rst_stale", stale, 1'b0);
        check8("mid_rst_overrun", overrun_cnt, 8'd0);
        check1("mid_rst_timeout", timeout_err, 1'b0);
        check1("mid_rst_phys_start", phys_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        step_to(16);
        check1("post_rst_busy_c16", frame_busy, 1'b0);
        step_to(17);
        check1("post_rst_busy_c17", frame_busy, 1'b1);
        step_to(18);
        check1("post_rst_phys_start", phys_start, 1'b1);
        check1("post_rst_stale", stale, 1'b1);
        check96("post_rst_snap", snap_data, 96'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
